// File: rtl/can_frame_tx_pkg.sv
// can_frame_tx_pkg: frame states, CRC polynomial and CAN field lengths
package can_frame_tx_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
    } state_t;
    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int ID_LEN  = 11;
    localparam int DLC_LEN = 4;
    localparam int CRC_LEN = 15;
    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;
endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CRC-15, one bit per enabled cycle
module can_crc15
    import can_frame_tx_pkg::*;
(
    input  logic        aclk,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [14:0] crc
);
    always_ff @(posedge aclk)
        if (clear)
            crc <= '0;
        else if (enable)
            crc <= {crc[13:0], 1'b0} ^ ((bit_in ^ crc[14]) ? CRC15_POLY : 15'd0);
endmodule

// File: rtl/can_frame_tx.sv
// can_frame_tx: CAN base-frame transmitter with stuffing, CRC, ACK and bus monitoring
module can_frame_tx
    import can_frame_tx_pkg::*;
#(
    parameter int BIT_CLKS  = 10,
    parameter int SAMPLE_PT = 7
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_id,
    input  logic        req_rtr,
    input  logic [3:0]  req_dlc,
    input  logic [63:0] req_data,
    output logic        can_tx,
    input  logic        can_rx,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic        arb_lost,
    output logic        bit_err
);
    localparam int CW = $clog2(BIT_CLKS);
    state_t state, nxt, adv_st, ld_st;
    logic [5:0] bidx, adv_idx, ld_idx;
    logic [CW-1:0] cnt;
    logic [2:0] run;
    logic is_stuff, accept, at_end, at_smp, last_bit, stuff_now, ld_bit, arb_hit, berr_hit, crc_en;
    logic [10:0] id;
    logic rtr;
    logic [3:0] dlc;
    logic [63:0] data;
    logic [6:0] dlen;
    logic [14:0] crc;
    logic [15:0] arb_bits, crc_bits;
    logic [7:0] ctrl_bits;

    function automatic logic [6:0] flen(state_t s, logic [6:0] dl);
        case (s)
            S_ARB:   flen = 7'(ID_LEN + 1);
            S_CTRL:  flen = 7'(DLC_LEN + 2);
            S_DATA:  flen = dl;
            S_CRC:   flen = 7'(CRC_LEN);
            S_EOF:   flen = 7'(EOF_LEN);
            S_IFS:   flen = 7'(IFS_LEN);
            default: flen = 7'd1;
        endcase
    endfunction

    can_crc15 u_crc (
        .aclk   (aclk),
        .clear  (arst || accept),
        .enable (crc_en),
        .bit_in (ld_bit),
        .crc    (crc)
    );

    assign req_ready = state == S_IDLE && !done;
    assign busy      = state != S_IDLE;
    assign accept    = req_valid && req_ready;

    // (state, bidx) names the field bit on the wire, or the pending one while a stuff bit is out
    always_comb begin
        at_end    = cnt == CW'(BIT_CLKS - 1);
        at_smp    = cnt == CW'(SAMPLE_PT);
        dlen      = rtr ? 7'd0 : (dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000});
        last_bit  = {1'b0, bidx} == flen(state, dlen) - 7'd1;
        nxt       = (state == S_CTRL && dlen == 7'd0) ? S_CRC :
                    (state == S_IFS ? S_IDLE : state_t'(state + 4'd1));
        adv_st    = last_bit ? nxt : state;
        adv_idx   = last_bit ? 6'd0 : bidx + 6'd1;
        ld_st     = is_stuff ? state : adv_st;
        ld_idx    = is_stuff ? bidx : adv_idx;
        arb_bits  = {id, rtr, 4'b0000};
        ctrl_bits = {2'b00, dlc, 2'b00};
        crc_bits  = {crc, 1'b0};
        ld_bit    = ld_st == S_SOF  ? 1'b0 :
                    ld_st == S_ARB  ? arb_bits[4'(15 - ld_idx)] :
                    ld_st == S_CTRL ? ctrl_bits[3'(7 - ld_idx)] :
                    ld_st == S_DATA ? data[6'(63 - ld_idx)] :
                    ld_st == S_CRC  ? crc_bits[4'(15 - ld_idx)] : 1'b1;
        stuff_now = !is_stuff && run == 3'd5 && (state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC});
        crc_en    = at_end && !stuff_now && state != S_IDLE && (ld_st inside {S_ARB, S_CTRL, S_DATA});
        arb_hit   = state == S_ARB && can_tx && !can_rx;
        berr_hit  = !(state inside {S_IDLE, S_ARB, S_ACK_SLOT}) && can_rx != can_tx;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bidx     <= '0;
            run      <= '0;
            is_stuff <= 1'b0;
            can_tx   <= 1'b1;
            done     <= 1'b0;
            ack_ok   <= 1'b0;
            arb_lost <= 1'b0;
            bit_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= (accept || at_end) ? '0 : cnt + 1'b1;
            if (accept) begin
                id       <= req_id;
                rtr      <= req_rtr;
                dlc      <= req_dlc;
                data     <= req_data;
                state    <= S_SOF;
                bidx     <= '0;
                run      <= 3'd1;
                is_stuff <= 1'b0;
                can_tx   <= 1'b0;
                ack_ok   <= 1'b0;
                arb_lost <= 1'b0;
                bit_err  <= 1'b0;
            end else if (state != S_IDLE) begin
                if (at_smp && (arb_hit || berr_hit)) begin
                    arb_lost <= arb_hit;
                    bit_err  <= berr_hit;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                    can_tx   <= 1'b1;
                end else begin
                    if (at_smp && state == S_ACK_SLOT && !can_rx)
                        ack_ok <= 1'b1;
                    // done lands on the final cycle of the last IFS bit
                    if (state == S_IFS && bidx == 6'(IFS_LEN - 1) && cnt == CW'(BIT_CLKS - 2))
                        done <= 1'b1;
                    if (at_end) begin
                        if (stuff_now) begin
                            can_tx   <= ~can_tx;
                            is_stuff <= 1'b1;
                            run      <= 3'd1;
                            state    <= adv_st;
                            bidx     <= adv_idx;
                        end else begin
                            can_tx   <= ld_bit;
                            is_stuff <= 1'b0;
                            run      <= (ld_bit == can_tx) ? run + 3'd1 : 3'd1;
                            state    <= ld_st;
                            bidx     <= ld_idx;
                        end
                    end
                end
            end
        end
    end
endmodule
